// File: rtl/board_line_scanner_if.sv
// rtl/board_line_scanner_if.sv - scan request, board RAM read port and scan results bundle
interface board_line_scanner_if #(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int ADDR_W  = 5,
    parameter int COLOR_W = 24,
    parameter int CNT_W   = 5
);
    logic                      start;
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_row;
    logic [COLS*COLOR_W-1:0]   rd_data;
    logic                      busy;
    logic                      done;
    logic [ROWS-1:0]           full_mask;
    logic [CNT_W-1:0]          full_count;
    logic                      any_full;
    logic [ADDR_W-1:0]         bottom_full;
    logic                      top_occupied;

    modport master (
        output start,
        input  rd_en,
        input  rd_row,
        output rd_data,
        input  busy,
        input  done,
        input  full_mask,
        input  full_count,
        input  any_full,
        input  bottom_full,
        input  top_occupied
    );

    modport slave (
        input  start,
        output rd_en,
        output rd_row,
        input  rd_data,
        output busy,
        output done,
        output full_mask,
        output full_count,
        output any_full,
        output bottom_full,
        output top_occupied
    );
endinterface

// File: rtl/board_line_scanner.sv
// rtl/board_line_scanner.sv - sweeps all board rows, reports full rows, their count and top-row occupancy
module board_line_scanner #(
    parameter int                 COLS        = 10,
    parameter int                 ROWS        = 20,
    parameter int                 ADDR_W      = 5,
    parameter int                 COLOR_W     = 24,
    parameter int                 CNT_W       = 5,
    parameter logic [COLOR_W-1:0] EMPTY_COLOR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    board_line_scanner_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic               rd_en_q, rd_en_n;
    logic [ADDR_W-1:0]  rd_row_q, rd_row_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [ROWS-1:0]    mask_q, mask_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               any_q, any_n;
    logic [ADDR_W-1:0]  bottom_q, bottom_n;
    logic               top_q, top_n;

    logic               row_full;
    logic               row_occ;
    logic               eval_en;
    logic [ADDR_W-1:0]  eval_row;

    always_comb begin
        row_full = 1'b1;
        row_occ  = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (bus.rd_data[i*COLOR_W +: COLOR_W] == EMPTY_COLOR)
                row_full = 1'b0;
            else
                row_occ = 1'b1;
        end
    end

    // RAM data lags the address by one cycle, so SCAN judges the previous row
    // and DRAIN picks up the last row after the address phase has ended.
    assign eval_en  = ((state == SCAN) && (rd_row_q != '0)) || (state == DRAIN);
    assign eval_row = (state == DRAIN) ? ADDR_W'(ROWS - 1) : (rd_row_q - ADDR_W'(1));

    always_comb begin
        state_n  = state;
        rd_en_n  = rd_en_q;
        rd_row_n = rd_row_q;
        busy_n   = busy_q;
        done_n   = done_q;
        mask_n   = mask_q;
        cnt_n    = cnt_q;
        any_n    = any_q;
        bottom_n = bottom_q;
        top_n    = top_q;

        case (state)
            IDLE: begin
                rd_en_n  = 1'b0;
                rd_row_n = '0;
                busy_n   = 1'b0;
                done_n   = 1'b0;
                if (bus.start) begin
                    mask_n   = '0;
                    cnt_n    = '0;
                    any_n    = 1'b0;
                    bottom_n = '0;
                    top_n    = 1'b0;
                    rd_en_n  = 1'b1;
                    busy_n   = 1'b1;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (rd_row_q == ADDR_W'(ROWS - 1)) begin
                    rd_en_n = 1'b0;
                    state_n = DRAIN;
                end else begin
                    rd_row_n = rd_row_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                rd_row_n = '0;
                busy_n   = 1'b0;
                done_n   = 1'b1;
                state_n  = DONE;
            end
            DONE: begin
                done_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Rows arrive in ascending order, so bottom_full ends on the lowest full row.
        if (eval_en && row_full) begin
            for (int k = 0; k < ROWS; k++) begin
                if (eval_row == ADDR_W'(k))
                    mask_n[k] = 1'b1;
            end
            if (cnt_q != {CNT_W{1'b1}})
                cnt_n = cnt_q + CNT_W'(1);
            any_n    = 1'b1;
            bottom_n = eval_row;
        end
        if (eval_en && (eval_row == '0) && row_occ)
            top_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_en_q  <= 1'b0;
            rd_row_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
            any_q    <= 1'b0;
            bottom_q <= '0;
            top_q    <= 1'b0;
        end else begin
            state    <= state_n;
            rd_en_q  <= rd_en_n;
            rd_row_q <= rd_row_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            mask_q   <= mask_n;
            cnt_q    <= cnt_n;
            any_q    <= any_n;
            bottom_q <= bottom_n;
            top_q    <= top_n;
        end
    end

    assign bus.rd_en        = rd_en_q;
    assign bus.rd_row       = rd_row_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.full_mask    = mask_q;
    assign bus.full_count   = cnt_q;
    assign bus.any_full     = any_q;
    assign bus.bottom_full  = bottom_q;
    assign bus.top_occupied = top_q;

endmodule

// File: tb/tb_board_line_scanner.sv
// tb/tb_board_line_scanner.sv - directed self-checking bench for board_line_scanner
module tb_board_line_scanner;
    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int ADDR_W  = 5;
    localparam int COLOR_W = 24;
    localparam int CNT_W   = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [COLS*COLOR_W-1:0] board [ROWS];

    board_line_scanner_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W),
                            .COLOR_W(COLOR_W), .CNT_W(CNT_W)) bus ();

    board_line_scanner #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W),
                         .COLOR_W(COLOR_W), .CNT_W(CNT_W), .EMPTY_COLOR(24'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One-cycle-latency column RAM model
    always @(posedge clk) bus.rd_data <= board[bus.rd_row];

    task automatic fill_all(input logic [COLOR_W-1:0] col);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board[r][c*COLOR_W +: COLOR_W] = col;
    endtask

    task automatic set_cell(input int r, input int c, input logic [COLOR_W-1:0] col);
        board[r][c*COLOR_W +: COLOR_W] = col;
    endtask

    // Start accepted at edge 0; cycle c is sampled at the negedge after edge c-1.
    task automatic run_scan(input int rst_cyc, input int x1, input int x2,
                            output int done_cyc, output int done_cnt, output int seq_err);
        done_cyc = 0;
        done_cnt = 0;
        seq_err  = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (rst_cyc == 0) begin
                if (bus.busy !== (c <= 21)) seq_err++;
                if (c <= 20 && (bus.rd_en !== 1'b1 || bus.rd_row !== 5'(c - 1))) seq_err++;
                if (c >= 21 && bus.rd_en !== 1'b0) seq_err++;
                if (c >= 22 && bus.rd_row !== 5'd0) seq_err++;
            end else if (c > rst_cyc) begin
                if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.rd_row !== 5'd0) seq_err++;
            end
            bus.start = (c == x1 || c == x2);
            rst_n     = !(c == rst_cyc);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        fill_all(24'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.rd_en !== 1'b0 || bus.rd_row !== 5'd0) begin errors++; $display("FAIL reset_rd got en=%b row=%0d want en=0 row=0", bus.rd_en, bus.rd_row); end
        checks++; if (bus.full_mask !== 20'h0 || bus.full_count !== 5'd0 || bus.any_full !== 1'b0 || bus.bottom_full !== 5'd0 || bus.top_occupied !== 1'b0) begin
            errors++; $display("FAIL reset_results got mask=%h cnt=%0d any=%b bot=%0d top=%b want all 0", bus.full_mask, bus.full_count, bus.any_full, bus.bottom_full, bus.top_occupied); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int dc, dn, se;
        fill_all(24'h0);
        run_scan(0, 0, 0, dc, dn, se);
        checks++; if (dc !== 22) begin errors++; $display("FAIL empty_done_cycle got %0d want 22", dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL empty_done_count got %0d want 1", dn); end
        checks++; if (se !== 0) begin errors++; $display("FAIL empty_sequence got %0d bad cycles want 0", se); end
        checks++; if (bus.full_mask !== 20'h0 || bus.full_count !== 5'd0 || bus.any_full !== 1'b0 || bus.top_occupied !== 1'b0) begin
            errors++; $display("FAIL empty_results got mask=%h cnt=%0d any=%b top=%b want 0 0 0 0", bus.full_mask, bus.full_count, bus.any_full, bus.top_occupied); end
    endtask

    task automatic test_all_full();
        int dc, dn, se;
        fill_all(24'hFF3399);
        run_scan(0, 0, 0, dc, dn, se);
        checks++; if (dc !== 22 || dn !== 1 || se !== 0) begin errors++; $display("FAIL all_full_timing got done_cyc=%0d n=%0d seq=%0d want 22 1 0", dc, dn, se); end
        checks++; if (bus.full_mask !== 20'hFFFFF) begin errors++; $display("FAIL all_full_mask got %h want fffff", bus.full_mask); end
        checks++; if (bus.full_count !== 5'd20) begin errors++; $display("FAIL all_full_count got %0d want 20", bus.full_count); end
        checks++; if (bus.bottom_full !== 5'd19 || bus.any_full !== 1'b1) begin errors++; $display("FAIL all_full_bottom got bot=%0d any=%b want 19 1", bus.bottom_full, bus.any_full); end
        checks++; if (bus.top_occupied !== 1'b1) begin errors++; $display("FAIL all_full_top got %b want 1", bus.top_occupied); end
    endtask

    task automatic test_two_rows();
        int dc, dn, se;
        fill_all(24'h0);
        for (int c = 0; c < COLS; c++) begin
            set_cell(19, c, 24'h123456);
            set_cell(17, c, 24'h00FF00);
            if (c != 9) set_cell(18, c, 24'hABCDEF);
        end
        run_scan(0, 0, 0, dc, dn, se);
        checks++; if (bus.full_mask !== 20'hA0000) begin errors++; $display("FAIL two_rows_mask got %h want a0000", bus.full_mask); end
        checks++; if (bus.full_count !== 5'd2 || bus.any_full !== 1'b1) begin errors++; $display("FAIL two_rows_count got cnt=%0d any=%b want 2 1", bus.full_count, bus.any_full); end
        checks++; if (bus.bottom_full !== 5'd19 || bus.top_occupied !== 1'b0) begin errors++; $display("FAIL two_rows_bottom got bot=%0d top=%b want 19 0", bus.bottom_full, bus.top_occupied); end
    endtask

    task automatic test_top_only();
        int dc, dn, se;
        fill_all(24'h0);
        set_cell(0, 4, 24'h66B2FF);
        run_scan(0, 0, 0, dc, dn, se);
        checks++; if (bus.top_occupied !== 1'b1) begin errors++; $display("FAIL top_only_top got %b want 1", bus.top_occupied); end
        checks++; if (bus.full_mask !== 20'h0 || bus.full_count !== 5'd0 || bus.any_full !== 1'b0 || bus.bottom_full !== 5'd0) begin
            errors++; $display("FAIL top_only_results got mask=%h cnt=%0d any=%b bot=%0d want 0", bus.full_mask, bus.full_count, bus.any_full, bus.bottom_full); end
    endtask

    task automatic test_back_to_back();
        int dc, dn, se;
        fill_all(24'h0);
        for (int c = 0; c < COLS; c++) begin
            set_cell(5, c, 24'h0000FF);
            set_cell(11, c, 24'hFF0000);
        end
        run_scan(0, 3, 21, dc, dn, se);
        checks++; if (dc !== 22 || dn !== 1) begin errors++; $display("FAIL extra_start_done got cyc=%0d n=%0d want 22 1", dc, dn); end
        checks++; if (se !== 0) begin errors++; $display("FAIL extra_start_sequence got %0d bad cycles want 0", se); end
        checks++; if (bus.full_mask !== 20'h00820 || bus.full_count !== 5'd2 || bus.bottom_full !== 5'd11) begin
            errors++; $display("FAIL extra_start_results got mask=%h cnt=%0d bot=%0d want 00820 2 11", bus.full_mask, bus.full_count, bus.bottom_full); end
    endtask

    task automatic test_reset_mid();
        int dc, dn, se;
        fill_all(24'h0);
        for (int c = 0; c < COLS; c++) set_cell(2, c, 24'h777777);
        set_cell(0, 0, 24'h010101);
        run_scan(10, 0, 0, dc, dn, se);
        checks++; if (dn !== 0) begin errors++; $display("FAIL reset_mid_done got %0d pulses want 0", dn); end
        checks++; if (se !== 0) begin errors++; $display("FAIL reset_mid_idle got %0d bad cycles want 0", se); end
        checks++; if (bus.full_mask !== 20'h0 || bus.full_count !== 5'd0 || bus.any_full !== 1'b0 || bus.bottom_full !== 5'd0 || bus.top_occupied !== 1'b0) begin
            errors++; $display("FAIL reset_mid_results got mask=%h cnt=%0d any=%b bot=%0d top=%b want 0", bus.full_mask, bus.full_count, bus.any_full, bus.bottom_full, bus.top_occupied); end
        run_scan(0, 0, 0, dc, dn, se);
        checks++; if (dc !== 22 || dn !== 1 || se !== 0) begin errors++; $display("FAIL reset_mid_rescan got cyc=%0d n=%0d seq=%0d want 22 1 0", dc, dn, se); end
        checks++; if (bus.full_mask !== 20'h00004 || bus.full_count !== 5'd1 || bus.bottom_full !== 5'd2 || bus.top_occupied !== 1'b1) begin
            errors++; $display("FAIL reset_mid_rescan_results got mask=%h cnt=%0d bot=%0d top=%b want 00004 1 2 1", bus.full_mask, bus.full_count, bus.bottom_full, bus.top_occupied); end
    endtask

    initial begin
        bus.start = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_empty();
        test_all_full();
        test_two_rows();
        test_top_only();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
